// File: rtl/conv_host.sv
// Host-side responder for the CONV accelerator: owns the image and layer memories,
// answers accelerator memory traffic, runs the ready/busy handshake and measures each run.
module conv_host #(
    parameter logic [31:0] TIMEOUT = 32'd400000,
    parameter int          DATA_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [11:0]       load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic              ready,
    input  logic              busy,
    input  logic [11:0]       iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              cwr,
    input  logic [11:0]       caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [11:0]       caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic [2:0]        csel,
    input  logic [2:0]        dump_sel,
    input  logic [11:0]       dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycles,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_t;

    localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

    state_t state, state_nxt;

    logic [DATA_W-1:0] image_mem [4096];
    logic [DATA_W-1:0] l0_mem0   [4096];
    logic [DATA_W-1:0] l0_mem1   [4096];
    logic [DATA_W-1:0] l1_mem0   [1024];
    logic [DATA_W-1:0] l1_mem1   [1024];
    logic [DATA_W-1:0] l2_mem    [2048];

    logic wr_err, rd_err;

    function automatic logic addr_ok(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            3'b001, 3'b010: return 1'b1;
            3'b011, 3'b100: return (addr < 12'd1024);
            3'b101:         return (addr < 12'd2048);
            default:        return 1'b0;
        endcase
    endfunction

    // Out-of-range or unmapped reads return zero rather than aliasing into a bank.
    function automatic logic [DATA_W-1:0] bank_read(input logic [2:0] sel, input logic [11:0] addr);
        if (!addr_ok(sel, addr)) return '0;
        case (sel)
            3'b001:  return l0_mem0[addr];
            3'b010:  return l0_mem1[addr];
            3'b011:  return l1_mem0[addr[9:0]];
            3'b100:  return l1_mem1[addr[9:0]];
            default: return l2_mem[addr[10:0]];
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign idata     = image_mem[iaddr];
    assign cdata_rd  = crd ? bank_read(csel, caddr_rd) : '0;
    assign dump_data = bank_read(dump_sel, dump_addr);

    // Valid accesses outside RUN still take effect; they are only counted.
    assign wr_err = cwr & (~addr_ok(csel, caddr_wr) | (state != S_RUN));
    assign rd_err = crd & (~addr_ok(csel, caddr_rd) | (state != S_RUN));

    always_ff @(posedge clk) begin
        if (load_valid && state == S_IDLE)
            image_mem[load_addr] <= load_data;
        if (cwr && addr_ok(csel, caddr_wr)) begin
            case (csel)
                3'b001:  l0_mem0[caddr_wr]        <= cdata_wr;
                3'b010:  l0_mem1[caddr_wr]        <= cdata_wr;
                3'b011:  l1_mem0[caddr_wr[9:0]]   <= cdata_wr;
                3'b100:  l1_mem1[caddr_wr[9:0]]   <= cdata_wr;
                default: l2_mem[caddr_wr[10:0]]   <= cdata_wr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READY;
            S_READY: begin
                ready = 1'b1;
                if (busy) state_nxt = S_RUN;
            end
            S_RUN:   if (!busy || cycles == TO_LAST) state_nxt = S_DONE;
            S_DONE:  begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles  <= '0;
            err_cnt <= '0;
            timeout <= 1'b0;
        end else if (state == S_IDLE && start) begin
            cycles  <= '0;
            err_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            err_cnt <= sat_add(err_cnt, {1'b0, wr_err} + {1'b0, rd_err});
            if (state == S_RUN) begin
                cycles <= cycles + 32'd1;
                if (cycles == TO_LAST) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_host.sv
// Directed bench for conv_host: scoreboard queue of expected values, immediate assertions at each check.
module tb_conv_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [11:0] load_addr;
    logic [19:0] load_data;
    logic        start;
    logic        busy;
    logic [11:0] iaddr;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [2:0]  csel;
    logic [2:0]  dump_sel;
    logic [11:0] dump_addr;

    logic        ready, done, timeout;
    logic [19:0] idata, cdata_rd, dump_data;
    logic [31:0] cycles;
    logic [7:0]  err_cnt;

    logic        ready2, done2, timeout2;
    logic [19:0] idata2, cdata_rd2, dump_data2;
    logic [31:0] cycles2;
    logic [7:0]  err_cnt2;

    logic [31:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_host u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
        .load_data(load_data), .start(start), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
        .done(done), .timeout(timeout), .cycles(cycles), .err_cnt(err_cnt)
    );

    conv_host #(.TIMEOUT(32'd50)) u_to (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
        .load_data(load_data), .start(start), .ready(ready2), .busy(busy),
        .iaddr(iaddr), .idata(idata2), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd2),
        .csel(csel), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data2),
        .done(done2), .timeout(timeout2), .cycles(cycles2), .err_cnt(err_cnt2)
    );

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        n_assert++;
        assert (obs === e)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    initial begin
        int rdy_cnt, done_cnt, done2_cnt, done_at;

        reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; busy = 1'b0; iaddr = '0; cwr = 1'b0; caddr_wr = '0;
        cdata_wr = '0; crd = 1'b0; caddr_rd = '0; csel = '0; dump_sel = '0; dump_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        expect_val(0); check("rst_ready", {31'd0, ready});
        expect_val(0); check("rst_done", {31'd0, done});
        expect_val(0); check("rst_timeout", {31'd0, timeout});
        expect_val(0); check("rst_cycles", cycles);
        expect_val(0); check("rst_err_cnt", {24'd0, err_cnt});
        reset = 1'b0;

        // Image load and combinational readback at both ends of the array
        @(negedge clk); load_valid = 1'b1; load_addr = 12'd0;    load_data = 20'h0A000;
        @(negedge clk); load_addr = 12'd4095; load_data = 20'h01234;
        @(negedge clk); load_addr = 12'd1;    load_data = 20'h11111;
        @(negedge clk); load_valid = 1'b0;
        iaddr = 12'd0;    #1; expect_val(20'h0A000); check("idata_0", idata);
        iaddr = 12'd4095; #1; expect_val(20'h01234); check("idata_4095", idata);

        // Double erroneous access per cycle in IDLE, then saturation at 255
        @(negedge clk); cwr = 1'b1; crd = 1'b1; csel = 3'b000;
        @(negedge clk); expect_val(2); check("err_double", {24'd0, err_cnt});
        repeat (129) @(negedge clk);
        cwr = 1'b0; crd = 1'b0;
        @(negedge clk); expect_val(255); check("err_saturate", {24'd0, err_cnt});

        // Run 1: ready held three cycles, busy for 100 cycles; u_to aborts at 50
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        expect_val(0); check("start_clears_err", {24'd0, err_cnt});
        rdy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (ready) rdy_cnt++;
            if (i == 2) busy = 1'b1;
        end
        expect_val(3); check("ready_cycles", rdy_cnt);
        done2_cnt = 0;
        @(negedge clk);
        expect_val(0); check("ready_drop", {31'd0, ready});
        for (int i = 0; i < 99; i++) begin
            if (done2) done2_cnt++;
            @(negedge clk);
        end
        busy = 1'b0;
        done_cnt = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        expect_val(1);   check("done_pulses", done_cnt);
        expect_val(0);   check("done_latency", done_at);
        expect_val(100); check("run_cycles", cycles);
        expect_val(0);   check("run_timeout", {31'd0, timeout});
        expect_val(1);   check("to_done_pulses", done2_cnt);
        expect_val(50);  check("to_cycles", cycles2);
        expect_val(1);   check("to_timeout", {31'd0, timeout2});

        // Valid write outside RUN executes but counts as an error
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd5; cdata_wr = 20'h55555;
        @(negedge clk); cwr = 1'b0;
        expect_val(1); check("idle_wr_err", {24'd0, err_cnt});
        dump_sel = 3'b001; dump_addr = 12'd5; #1;
        expect_val(20'h55555); check("idle_wr_lands", dump_data);

        // Run 2: layer memory traffic inside RUN
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; busy = 1'b1;
        @(negedge clk);
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd1023; cdata_wr = 20'h00ABC;
        @(negedge clk); cwr = 1'b0;
        expect_val(0); check("l1_wr_ok_err", {24'd0, err_cnt});
        crd = 1'b1; caddr_rd = 12'd1023; #1;
        expect_val(20'h00ABC); check("l1_rd_1023", cdata_rd);
        crd = 1'b0;
        cwr = 1'b1; caddr_wr = 12'd1024; cdata_wr = 20'hFFFFF;
        @(negedge clk); cwr = 1'b0;
        expect_val(1); check("l1_range_err", {24'd0, err_cnt});
        dump_sel = 3'b011; dump_addr = 12'd1023; #1;
        expect_val(20'h00ABC); check("dump_l1_1023", dump_data);
        dump_addr = 12'd1024; #1;
        expect_val(0); check("dump_l1_1024", dump_data);

        // Same-cycle write/read on L2: old data first, new data next cycle
        cwr = 1'b1; csel = 3'b101; caddr_wr = 12'd7; cdata_wr = 20'h00001;
        @(negedge clk); cdata_wr = 20'h00002; crd = 1'b1; caddr_rd = 12'd7; #1;
        expect_val(20'h00001); check("l2_rw_old", cdata_rd);
        @(negedge clk); cwr = 1'b0; #1;
        expect_val(20'h00002); check("l2_rw_new", cdata_rd);
        crd = 1'b0; #1;
        expect_val(0); check("crd_low_zero", cdata_rd);

        // Load outside IDLE is ignored
        load_valid = 1'b1; load_addr = 12'd1; load_data = 20'h22222;
        @(negedge clk); load_valid = 1'b0;
        iaddr = 12'd1; #1;
        expect_val(20'h11111); check("load_ignored", idata);

        // Reset in the middle of RUN
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; busy = 1'b0;
        expect_val(0); check("mid_rst_ready", {31'd0, ready});
        expect_val(0); check("mid_rst_cycles", cycles);
        expect_val(0); check("mid_rst_err", {24'd0, err_cnt});
        expect_val(0); check("mid_rst_to2", {31'd0, timeout2});
        @(negedge clk);
        expect_val(0); check("mid_rst_no_done", {31'd0, done});
        iaddr = 12'd0;    #1; expect_val(20'h0A000); check("img_kept_0", idata);
        iaddr = 12'd4095; #1; expect_val(20'h01234); check("img_kept_4095", idata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
